// File: rtl/status_tx_if.sv
// Status packet request/serial-output bundle between the telemetry
// top level (master) and the status packet transmitter (slave).
interface status_tx_if;
    logic        send;
    logic        pwr_up;
    logic        rider_off;
    logic        batt_low;
    logic [11:0] weight;
    logic        TX;
    logic        busy;
    logic        done;

    modport master (
        output send, pwr_up, rider_off, batt_low, weight,
        input  TX, busy, done
    );

    modport slave (
        input  send, pwr_up, rider_off, batt_low, weight,
        output TX, busy, done
    );
endinterface

// File: rtl/status_tx.sv
// Status packet UART transmitter: sequences A5/status/wt_hi/wt_lo/chk
// and serializes each byte as 8N1 at CLK_FREQ_HZ/BAUD_RATE clocks per bit.
module status_tx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic  clk,
    input  logic  rst,
    status_tx_if.slave bus
);

    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_status;
    logic [7:0]    r_wt_hi;
    logic [7:0]    r_wt_lo;

    logic          w_tick;
    logic [7:0]    w_chk;
    logic [7:0]    w_next_byte;

    assign w_tick = (r_baud == BAUD_LAST);
    assign w_chk  = ~(r_status + r_wt_hi + r_wt_lo);

    // Byte that follows the one currently being sent (header comes from accept).
    always_comb begin
        w_next_byte = 8'hA5;
        case (r_idx)
            3'd0:    w_next_byte = r_status;
            3'd1:    w_next_byte = r_wt_hi;
            3'd2:    w_next_byte = r_wt_lo;
            3'd3:    w_next_byte = w_chk;
            default: w_next_byte = 8'hA5;
        endcase
    end

    // Packet sequencer and bit serializer with registered TX/busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_idx    <= 3'd0;
            r_baud   <= '0;
            r_bit    <= 3'd0;
            r_shift  <= 8'hFF;
            r_status <= 8'h00;
            r_wt_hi  <= 8'h00;
            r_wt_lo  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud <= w_tick ? '0 : r_baud + CW'(1);
            end
            unique case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_idx  <= 3'd0;
                    r_bit  <= 3'd0;
                    if (bus.send) begin
                        r_busy   <= 1'b1;
                        r_status <= {5'b0, bus.batt_low,
                                     bus.rider_off, bus.pwr_up};
                        r_wt_hi  <= {4'b0, bus.weight[11:8]};
                        r_wt_lo  <= bus.weight[7:0];
                        r_shift  <= 8'hA5;
                        r_tx     <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_idx < 3'd4) begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= w_next_byte;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.TX   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_status_tx.sv
// Bench for status_tx: per-cycle compare against a packet-level model,
// plus UART-decoded byte checks against hand-computed packets.
module tb_status_tx;

    localparam int BD  = 16;
    localparam int PKT = 50 * BD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    bit   chk_en = 1'b0;

    status_tx_if bus ();

    status_tx #(
        .CLK_FREQ_HZ (16),
        .BAUD_RATE   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Packet-level model: a frame is 50 bits, each held BD cycles.
    logic       m_tx = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    int         m_n = 0;
    logic       m_bits [50];

    function automatic logic [39:0] pkt_bytes(
        input logic p, input logic r, input logic b,
        input logic [11:0] w);
        int s, h, l, c;
        s = 4 * int'(b) + 2 * int'(r) + int'(p);
        h = int'(w) / 256;
        l = int'(w) % 256;
        c = 255 - ((s + h + l) % 256);
        return {8'hA5, 8'(s), 8'(h), 8'(l), 8'(c)};
    endfunction

    always @(posedge clk) begin
        logic [39:0] pb;
        logic [7:0]  by;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_tx   = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_n = m_n + 1;
                if (m_n == PKT) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_tx   = 1'b1;
                end else begin
                    m_tx = m_bits[m_n / BD];
                end
            end else if (bus.send) begin
                pb = pkt_bytes(bus.pwr_up, bus.rider_off,
                               bus.batt_low, bus.weight);
                for (int i = 0; i < 5; i++) begin
                    by = pb[39 - 8*i -: 8];
                    m_bits[10*i] = 1'b0;
                    for (int j = 0; j < 8; j++)
                        m_bits[10*i + 1 + j] = by[j];
                    m_bits[10*i + 9] = 1'b1;
                end
                m_busy = 1'b1;
                m_n    = 0;
                m_tx   = m_bits[0];
            end
        end
    end

    // Per-cycle compare of TX/busy/done against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec = n_vec + 1;
            if (bus.done) done_cnt = done_cnt + 1;
            if ({bus.TX, bus.busy, bus.done} !== {m_tx, m_busy, m_done}) begin
                n_err = n_err + 1;
                if (n_err <= 20)
                    $display("FAIL cycle%0d tx/busy/done got %b%b%b want %b%b%b",
                             cyc, bus.TX, bus.busy, bus.done,
                             m_tx, m_busy, m_done);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got 0x%0h want 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic send_pulse(output int k);
        @(negedge clk);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        k = cyc;
    endtask

    task automatic pulse_at(input int e, input int len);
        wait_cyc(e - 1);
        bus.send = 1'b1;
        wait_cyc(e + len - 1);
        bus.send = 1'b0;
    endtask

    // Mid-bit UART decode of TX for the packet accepted at edge k.
    task automatic capture(input int k, output logic [39:0] bytes);
        logic [9:0] fr;
        bytes = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 10; j++) begin
                wait_cyc(k + BD * (10*i + j) + BD/2);
                fr[j] = bus.TX;
            end
            chk("start_bit", int'(fr[0]), 0);
            chk("stop_bit", int'(fr[9]), 1);
            bytes[39 - 8*i -: 8] = fr[8:1];
        end
    endtask

    task automatic chk_pkt(input string name, input logic [39:0] got,
                           input logic [39:0] exp);
        for (int i = 0; i < 5; i++)
            chk(name, int'(got[39 - 8*i -: 8]), int'(exp[39 - 8*i -: 8]));
    endtask

    task automatic set_in(input logic p, input logic r, input logic b,
                          input logic [11:0] w);
        bus.pwr_up    = p;
        bus.rider_off = r;
        bus.batt_low  = b;
        bus.weight    = w;
    endtask

    initial begin
        int k;
        int k2;
        logic [39:0] got;
        logic [39:0] got2;
        bus.send = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 12'h000);

        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_tx", int'(bus.TX), 1);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_done_cnt", done_cnt, 0);

        set_in(1'b1, 1'b0, 1'b1, 12'h2C4);
        send_pulse(k);
        capture(k, got);
        chk_pkt("pkt1", got, 40'hA5_05_02_C4_34);
        wait_cyc(k + PKT + 2);
        chk("pkt1_done_cnt", done_cnt, 1);
        chk("pkt1_busy", int'(bus.busy), 0);

        set_in(1'b1, 1'b1, 1'b1, 12'hFFF);
        send_pulse(k);
        capture(k, got);
        chk_pkt("pkt2_wrap", got, 40'hA5_07_0F_FF_EA);
        wait_cyc(k + PKT + 2);
        chk("pkt2_done_cnt", done_cnt, 2);

        set_in(1'b0, 1'b1, 1'b0, 12'h1A3);
        send_pulse(k);
        k2 = k + PKT + 1;
        fork
            begin
                capture(k, got);
                capture(k2, got2);
            end
            begin
                wait_cyc(k + 5);
                set_in(1'b1, 1'b1, 1'b1, 12'h000);
                pulse_at(k + 10, 1);
                pulse_at(k + 400, 1);
                pulse_at(k + PKT, 2);
            end
        join
        chk_pkt("snapshot", got, 40'hA5_02_01_A3_59);
        chk_pkt("reaccept", got2, 40'hA5_07_00_00_F8);
        wait_cyc(k2 + PKT + 2);
        chk("pkt3_done_cnt", done_cnt, 4);

        set_in(1'b1, 1'b0, 1'b0, 12'h555);
        send_pulse(k);
        wait_cyc(k + 249);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_tx", int'(bus.TX), 1);
        chk("rst_mid_busy", int'(bus.busy), 0);
        wait_cyc(k + PKT + 20);
        chk("rst_mid_no_done", done_cnt, 4);

        set_in(1'b0, 1'b0, 1'b0, 12'h800);
        send_pulse(k);
        capture(k, got);
        chk_pkt("after_rst", got, 40'hA5_00_08_00_F7);
        wait_cyc(k + PKT + 2);
        chk("pkt5_done_cnt", done_cnt, 5);

        @(negedge clk);
        rst      = 1'b1;
        bus.send = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.send = 1'b0;
        chk("rst_send_busy", int'(bus.busy), 0);
        repeat (40) @(negedge clk);
        chk("rst_send_busy_late", int'(bus.busy), 0);
        chk("rst_send_tx", int'(bus.TX), 1);
        chk("final_done_cnt", done_cnt, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
